// File: rtl/psdu_fcs_check.sv
// psdu_fcs_check: checks the CRC-32 FCS of a descrambled PSDU, one byte per
// clock. A start pulse arms a check for pkt_len bytes (FCS included). One
// cycle after the final byte, a one-cycle result strobe is raised together
// with fcs_ok.
//
// Optional feature macro: PSDU_PAYLOAD_FWD_EN
//   When defined, the module forwards payload bytes with the FCS stripped.
//   Each byte leaves on pay_out only once four newer bytes have arrived
//   behind it, so the trailing four FCS bytes are never forwarded.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; byte strobes ignored
// RUN   | accepting bytes, CRC accumulating
// DONE  | result cycle: fcs_out_strobe high, return to IDLE next
module psdu_fcs_check (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_start,
   input  logic [15:0] i_pkt_len,
   input  logic [7:0]  i_byte_in,
   input  logic        i_byte_in_strobe,
   output logic        o_busy,
   output logic [15:0] o_byte_count,
   output logic        o_fcs_out_strobe,
   output logic        o_fcs_ok
`ifdef PSDU_PAYLOAD_FWD_EN
   ,
   output logic [7:0]  o_pay_out,
   output logic        o_pay_out_strobe
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   // Register value left behind when a frame's own FCS is run through the CRC.
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   state_t       r_state;
   logic [15:0]  r_pkt_len;
   logic [15:0]  r_byte_count;
   logic [31:0]  r_crc;
   logic         r_fcs_strobe;
   logic         r_fcs_ok;

   logic [31:0]  w_crc_next;
   logic [15:0]  w_count_next;
   logic         w_accept;
   logic         w_last;

   // Reflected CRC-32 over one byte, processed LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         x = x[0] ? ((x >> 1) ^ CRC_POLY) : (x >> 1);
      end
      return x;
   endfunction

   // A byte is taken only in RUN; start in the same cycle wins and drops it.
   always_comb begin
      w_crc_next   = crc_byte(r_crc, i_byte_in);
      w_count_next = r_byte_count + 16'd1;
      w_accept     = (r_state == ST_RUN) && i_byte_in_strobe && !i_start;
      w_last       = (w_count_next == r_pkt_len);
   end

   // Main control FSM with registered result outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_pkt_len    <= 16'd0;
         r_byte_count <= 16'd0;
         r_crc        <= CRC_INIT;
         r_fcs_strobe <= 1'b0;
         r_fcs_ok     <= 1'b0;
      end else if (i_enable) begin
         r_fcs_strobe <= 1'b0;
         if (i_start) begin
            // Start arms a fresh check in any state, aborting a packet in flight.
            r_pkt_len    <= i_pkt_len;
            r_byte_count <= 16'd0;
            r_crc        <= CRC_INIT;
            r_fcs_ok     <= 1'b0;
            if (i_pkt_len == 16'd0) begin
               r_state      <= ST_DONE;
               r_fcs_strobe <= 1'b1;
            end else begin
               r_state <= ST_RUN;
            end
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (w_accept) begin
                     r_crc        <= w_crc_next;
                     r_byte_count <= w_count_next;
                     if (w_last) begin
                        r_state      <= ST_DONE;
                        r_fcs_strobe <= 1'b1;
                        r_fcs_ok     <= (r_pkt_len >= 16'd4) && (w_crc_next == CRC_RESIDUE);
                     end
                  end
               end
               ST_DONE: r_state <= ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_busy           = (r_state == ST_RUN);
   assign o_byte_count     = r_byte_count;
   assign o_fcs_out_strobe = r_fcs_strobe;
   assign o_fcs_ok         = r_fcs_ok;

`ifdef PSDU_PAYLOAD_FWD_EN
   logic [7:0] r_dl [4];
   logic [2:0] r_dl_fill;
   logic [7:0] r_pay_out;
   logic       r_pay_strobe;

   // Four-byte delay line; the oldest byte is released once the line is full.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < 4; i++) r_dl[i] <= 8'h00;
         r_dl_fill    <= 3'd0;
         r_pay_out    <= 8'h00;
         r_pay_strobe <= 1'b0;
      end else if (i_enable) begin
         r_pay_strobe <= 1'b0;
         if (i_start) begin
            for (int i = 0; i < 4; i++) r_dl[i] <= 8'h00;
            r_dl_fill <= 3'd0;
         end else if (w_accept) begin
            r_dl[0] <= i_byte_in;
            r_dl[1] <= r_dl[0];
            r_dl[2] <= r_dl[1];
            r_dl[3] <= r_dl[2];
            if (r_dl_fill == 3'd4) begin
               r_pay_out    <= r_dl[3];
               r_pay_strobe <= 1'b1;
            end else begin
               r_dl_fill <= r_dl_fill + 3'd1;
            end
         end
      end
   end

   assign o_pay_out        = r_pay_out;
   assign o_pay_out_strobe = r_pay_strobe;
`endif

endmodule

// File: tb/tb_psdu_fcs_check.sv
// Directed bench for psdu_fcs_check. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
module tb_psdu_fcs_check;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        start;
   logic [15:0] pkt_len;
   logic [7:0]  byte_in;
   logic        byte_stb;
   logic        busy;
   logic [15:0] byte_count;
   logic        fcs_stb;
   logic        fcs_ok;
`ifdef PSDU_PAYLOAD_FWD_EN
   logic [7:0]  pay_out;
   logic        pay_stb;
   logic [7:0]  pay_q[$];
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int n_strb = 0;

   // "123456789" followed by its FCS, LSB-first of 0xCBF43926.
   logic [7:0] pkt_good [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

   psdu_fcs_check dut (
      .i_clock          (clk),
      .i_reset          (rst),
      .i_enable         (en),
      .i_start          (start),
      .i_pkt_len        (pkt_len),
      .i_byte_in        (byte_in),
      .i_byte_in_strobe (byte_stb),
      .o_busy           (busy),
      .o_byte_count     (byte_count),
      .o_fcs_out_strobe (fcs_stb),
      .o_fcs_ok         (fcs_ok)
`ifdef PSDU_PAYLOAD_FWD_EN
      ,
      .o_pay_out        (pay_out),
      .o_pay_out_strobe (pay_stb)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (fcs_stb) n_strb++;
`ifdef PSDU_PAYLOAD_FWD_EN
      if (pay_stb) pay_q.push_back(pay_out);
`endif
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_start(input logic [15:0] len);
      start   = 1'b1;
      pkt_len = len;
      tick();
      start   = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      byte_in  = b;
      byte_stb = 1'b1;
      tick();
      byte_stb = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; start = 1'b1; pkt_len = 16'd5; byte_in = 8'h00; byte_stb = 1'b1;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(byte_count), 32'd0);
      check("rst_strobe", 32'(fcs_stb), 32'd0);
      check("rst_ok", 32'(fcs_ok), 32'd0);
      rst = 1'b0; en = 1'b1; start = 1'b0; byte_stb = 1'b0;
      tick();

      // Good packet.
`ifdef PSDU_PAYLOAD_FWD_EN
      pay_q.delete();
`endif
      n_strb = 0;
      do_start(16'd13);
      check("good_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 12; i++) send(pkt_good[i]);
      check("good_cnt12", 32'(byte_count), 32'd12);
      check("good_nostrb12", 32'(fcs_stb), 32'd0);
      send(pkt_good[12]);
      check("good_strobe", 32'(fcs_stb), 32'd1);
      check("good_ok", 32'(fcs_ok), 32'd1);
      check("good_count", 32'(byte_count), 32'd13);
      check("good_busy_done", 32'(busy), 32'd0);
      tick();
      check("good_strobe_1cyc", 32'(fcs_stb), 32'd0);
      check("good_ok_held", 32'(fcs_ok), 32'd1);
      send(8'hAA);
      check("idle_byte_ignored", 32'(byte_count), 32'd13);
      check("good_nstrb", 32'(n_strb), 32'd1);
`ifdef PSDU_PAYLOAD_FWD_EN
      check("pay_count", 32'(pay_q.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         if (i < pay_q.size()) check($sformatf("pay_%0d", i), 32'(pay_q[i]), 32'(8'h31 + i));
`endif

      // Corrupted packet: byte 5 '5' -> 0x34.
      n_strb = 0;
      do_start(16'd13);
      check("bad_ok_cleared", 32'(fcs_ok), 32'd0);
      for (int i = 0; i < 13; i++) send(i == 4 ? 8'h34 : pkt_good[i]);
      check("bad_strobe", 32'(fcs_stb), 32'd1);
      check("bad_ok", 32'(fcs_ok), 32'd0);
      tick();
      check("bad_nstrb", 32'(n_strb), 32'd1);

      // Zero-length packet.
      n_strb = 0;
      do_start(16'd0);
      check("len0_strobe", 32'(fcs_stb), 32'd1);
      check("len0_ok", 32'(fcs_ok), 32'd0);
      check("len0_busy", 32'(busy), 32'd0);
      tick();
      check("len0_strobe_off", 32'(fcs_stb), 32'd0);
      check("len0_busy2", 32'(busy), 32'd0);

      // Restart after 6 bytes, then full good packet.
      n_strb = 0;
      do_start(16'd13);
      for (int i = 0; i < 6; i++) send(pkt_good[i]);
      do_start(16'd13);
      check("restart_count", 32'(byte_count), 32'd0);
      for (int i = 0; i < 13; i++) send(pkt_good[i]);
      tick();
      check("restart_nstrb", 32'(n_strb), 32'd1);
      check("restart_ok", 32'(fcs_ok), 32'd1);

      // Start coinciding with the final byte: packet aborted, byte dropped.
      n_strb = 0;
      do_start(16'd4);
      for (int i = 0; i < 3; i++) send(8'h00);
      byte_in = 8'h00; byte_stb = 1'b1; start = 1'b1; pkt_len = 16'd13;
      tick();
      byte_stb = 1'b0; start = 1'b0;
      check("collide_nostrb", 32'(fcs_stb), 32'd0);
      check("collide_count", 32'(byte_count), 32'd0);
      check("collide_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 13; i++) send(pkt_good[i]);
      tick();
      check("collide_nstrb", 32'(n_strb), 32'd1);
      check("collide_ok", 32'(fcs_ok), 32'd1);

      // Four-byte packet: empty payload + FCS 00 00 00 00 is valid.
      do_start(16'd4);
      for (int i = 0; i < 4; i++) send(8'h00);
      check("len4_ok", 32'(fcs_ok), 32'd1);
      tick();
      // Three-byte packet can never pass.
      do_start(16'd3);
      for (int i = 0; i < 3; i++) send(8'h00);
      check("len3_strobe", 32'(fcs_stb), 32'd1);
      check("len3_ok", 32'(fcs_ok), 32'd0);
      tick();

      // Enable low mid-packet, then reset after 8 bytes.
      n_strb = 0;
      do_start(16'd13);
      for (int i = 0; i < 4; i++) send(pkt_good[i]);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(8'hFF);
         check($sformatf("en_low_hold_%0d", i), 32'(byte_count), 32'd4);
      end
      en = 1'b1;
      for (int i = 4; i < 8; i++) send(pkt_good[i]);
      check("en_resume_count", 32'(byte_count), 32'd8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_count", 32'(byte_count), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 6; i++) send(pkt_good[8 + (i % 5)]);
      check("midrst_nstrb", 32'(n_strb), 32'd0);
      check("midrst_count2", 32'(byte_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
